// File: rtl/io_fabric_if.sv
// CPU-side system bus bundle between the mapper output and the io_fabric decoder.
interface io_fabric_if #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_SLOTS = 10
);
  logic [ADDR_W-1:0]                i_addr;
  logic                             i_rwb;
  logic [DATA_W-1:0]                i_data;
  logic [DATA_W-1:0]                o_data;
  logic                             o_rdy;
  logic [NUM_SLOTS:0]               o_cs;
  logic [(NUM_SLOTS+1)*DATA_W-1:0]  i_slot_data;
  logic [NUM_SLOTS:0]               i_slot_wait;
  logic                             o_irq;

  modport slave (
    input  i_addr, i_rwb, i_data, i_slot_data, i_slot_wait,
    output o_data, o_rdy, o_cs, o_irq
  );

  modport master (
    output i_addr, i_rwb, i_data, i_slot_data, i_slot_wait,
    input  o_data, o_rdy, o_cs, o_irq
  );
endinterface

// File: rtl/io_fabric.sv
// Address decoder, read mux and wait-state/timeout generator for the 6502 bus.
// Programmable windows, a default slot, and a 3-byte error status block.
module io_fabric #(
  parameter int unsigned                     ADDR_W     = 25,
  parameter int unsigned                     DATA_W     = 8,
  parameter int unsigned                     NUM_SLOTS  = 10,
  parameter logic [NUM_SLOTS*ADDR_W-1:0]     SLOT_BASE  = '1,
  parameter logic [NUM_SLOTS*ADDR_W-1:0]     SLOT_LIMIT = '0,
  parameter logic [(NUM_SLOTS+1)*4-1:0]      SLOT_WS    = '0,
  parameter int unsigned                     TIMEOUT    = 255,
  parameter logic [ADDR_W-1:0]               CSR_BASE   = ADDR_W'('h0efd0)
) (
  input logic        clk,
  input logic        reset,
  io_fabric_if.slave bus
);

  localparam int unsigned SW = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {StIdle, StStall, StAbort} state_e;

  state_e          state_q;
  logic [SW-1:0]   slot_q;
  logic [3:0]      ws_q;
  logic [15:0]     to_q;
  logic            err_q;
  logic [3:0]      err_slot_q;
  logic [15:0]     err_addr_q;

  logic              csr_hit;
  logic [ADDR_W-1:0] csr_diff;
  logic [1:0]        csr_off;
  logic [SW-1:0]     dec_slot;
  logic [3:0]        dec_ws;
  logic              dec_wait;
  logic              idle_done;
  logic              stall_done;
  logic [SW-1:0]     rd_slot;
  logic [DATA_W-1:0] slot_rdata;
  logic [DATA_W-1:0] csr_rdata;

  // Lowest-index window wins, so scan from the top and let lower hits overwrite.
  always_comb begin
    csr_hit  = (bus.i_addr >= CSR_BASE) && (bus.i_addr <= CSR_BASE + ADDR_W'(2));
    csr_diff = bus.i_addr - CSR_BASE;
    csr_off  = csr_diff[1:0];
    dec_slot = SW'(NUM_SLOTS);
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (bus.i_addr >= SLOT_BASE[k*ADDR_W +: ADDR_W] &&
          bus.i_addr <= SLOT_LIMIT[k*ADDR_W +: ADDR_W]) begin
        dec_slot = SW'(k);
      end
    end
    dec_ws     = SLOT_WS[dec_slot*4 +: 4];
    dec_wait   = bus.i_slot_wait[dec_slot];
    idle_done  = csr_hit || (dec_ws == 4'd0 && !dec_wait);
    stall_done = (ws_q <= 4'd1) && !bus.i_slot_wait[slot_q];
    rd_slot    = (state_q == StStall) ? slot_q : dec_slot;
    slot_rdata = bus.i_slot_data[rd_slot*DATA_W +: DATA_W];
    unique case (csr_off)
      2'd0:    csr_rdata = DATA_W'({err_q, 3'b000, err_slot_q});
      2'd1:    csr_rdata = DATA_W'(err_addr_q[7:0]);
      2'd2:    csr_rdata = DATA_W'(err_addr_q[15:8]);
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    bus.o_cs   = '0;
    bus.o_data = '0;
    bus.o_rdy  = 1'b0;
    case (state_q)
      StIdle: begin
        if (csr_hit) begin
          bus.o_data = csr_rdata;
        end else begin
          bus.o_cs[dec_slot] = 1'b1;
          bus.o_data         = slot_rdata;
        end
        bus.o_rdy = idle_done;
      end
      StStall: begin
        bus.o_cs[slot_q] = 1'b1;
        bus.o_data       = slot_rdata;
        bus.o_rdy        = stall_done;
      end
      StAbort: begin
        bus.o_data = '1;
        bus.o_rdy  = 1'b1;
      end
      default: ;
    endcase
    if (reset) bus.o_rdy = 1'b1;
  end

  assign bus.o_irq = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      slot_q     <= SW'(NUM_SLOTS);
      ws_q       <= 4'd0;
      to_q       <= 16'd0;
      err_q      <= 1'b0;
      err_slot_q <= 4'd0;
      err_addr_q <= 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (csr_hit) begin
            if (!bus.i_rwb && csr_off == 2'd0) begin
              err_q      <= 1'b0;
              err_slot_q <= 4'd0;
            end
          end else if (!idle_done) begin
            slot_q  <= dec_slot;
            ws_q    <= dec_ws;
            to_q    <= 16'd1;
            state_q <= StStall;
          end
        end
        StStall: begin
          ws_q <= (ws_q == 4'd0) ? 4'd0 : ws_q - 4'd1;
          if (stall_done) begin
            state_q <= StIdle;
          end else if (to_q >= 16'(TIMEOUT)) begin
            state_q <= StAbort;
          end else begin
            to_q <= to_q + 16'd1;
          end
        end
        StAbort: begin
          err_q      <= 1'b1;
          err_slot_q <= 4'(slot_q);
          err_addr_q <= bus.i_addr[15:0];
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_fabric.sv
// Directed bench for io_fabric: driver queues expected completions, monitor checks them.
module tb_io_fabric;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 8;
  localparam int unsigned NS = 10;
  localparam int unsigned TO = 8;

  // Slots 5..9 have base > limit and never match.
  localparam logic [NS*AW-1:0] BASE = {{5{25'h1ffffff}}, 25'h0efe0, 25'h28000, 25'h0eff8,
                                       25'h20000, 25'h01000};
  localparam logic [NS*AW-1:0] LIMIT = {{5{25'h0000000}}, 25'h0efef, 25'h3ffff, 25'h0effb,
                                        25'h2ffff, 25'h01fff};
  localparam logic [(NS+1)*4-1:0] WS = 44'h3;

  typedef struct {
    logic [NS:0] cs;
    logic [7:0]  data;
    int          waits;
    logic        irq;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic active = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   stall = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  io_fabric_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLOTS(NS)) bus ();

  io_fabric #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLOTS(NS), .SLOT_BASE(BASE), .SLOT_LIMIT(LIMIT),
    .SLOT_WS(WS), .TIMEOUT(TO), .CSR_BASE(25'h0efd0)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed access (o_rdy high while a transaction is active) pops one entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && active) begin
        if (!bus.o_rdy) begin
          stall++;
        end else begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion: got cs=%0h expected none", bus.o_cs);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_cs"}, 32'(bus.o_cs), 32'(e.cs));
            chk({e.name, "_data"}, 32'(bus.o_data), 32'(e.data));
            chk({e.name, "_waits"}, 32'(stall), 32'(e.waits));
            chk({e.name, "_irq"}, 32'(bus.o_irq), 32'(e.irq));
          end
          stall = 0;
        end
      end else begin
        stall = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic access(input string name, input logic [24:0] addr, input logic rwb,
                        input logic [7:0] wdata, input int wslot, input int wcyc,
                        input logic [24:0] new_addr, input logic [NS:0] cs,
                        input logic [7:0] data, input int waits, input logic irq);
    exp_t e;
    int   cyc;
    logic done;
    e.cs = cs; e.data = data; e.waits = waits; e.irq = irq; e.name = name;
    q.push_back(e);
    bus.i_addr = addr;
    bus.i_rwb  = rwb;
    bus.i_data = wdata;
    if (wslot >= 0 && wcyc > 0) bus.i_slot_wait[wslot] = 1'b1;
    active = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      done = bus.o_rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (cyc > 200) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got no completion after %0d cycles, expected one", name, cyc);
        void'(q.pop_back());
        break;
      end
      if (wslot >= 0 && cyc == wcyc) bus.i_slot_wait[wslot] = 1'b0;
      if (cyc == 1) bus.i_addr = new_addr;
    end
    bus.i_slot_wait = '0;
    bus.i_rwb = 1'b1;
    active = 1'b0;
  endtask

  initial begin
    bus.i_addr      = 25'h01234;
    bus.i_rwb       = 1'b1;
    bus.i_data      = 8'h00;
    bus.i_slot_wait = '0;
    for (int k = 0; k <= int'(NS); k++) bus.i_slot_data[k*8 +: 8] = 8'(8'hA0 + k);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", 32'(bus.o_rdy), 32'd1);
    chk("reset_irq", 32'(bus.o_irq), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    access("slot2_zero_ws", 25'h0eff9, 1'b1, 8'h00, -1, 0, 25'h0eff9, 11'h004, 8'hA2, 0, 1'b0);
    access("slot0_ws3", 25'h01234, 1'b1, 8'h00, -1, 0, 25'h0eff9, 11'h001, 8'hA0, 3, 1'b0);
    access("default_wait5", 25'h12345, 1'b1, 8'h00, 10, 5, 25'h12345, 11'h400, 8'hAA, 5,
           1'b0);
    access("abort_slot4", 25'h0efe6, 1'b1, 8'h00, 4, 1000, 25'h0efe6, 11'h000, 8'hFF,
           int'(TO) + 1, 1'b0);
    access("csr0_err", 25'h0efd0, 1'b1, 8'h00, -1, 0, 25'h0efd0, 11'h000, 8'h84, 0, 1'b1);
    access("csr1_lo", 25'h0efd1, 1'b1, 8'h00, -1, 0, 25'h0efd1, 11'h000, 8'he6, 0, 1'b1);
    access("csr2_hi", 25'h0efd2, 1'b1, 8'h00, -1, 0, 25'h0efd2, 11'h000, 8'hef, 0, 1'b1);
    access("csr2_wr_ignored", 25'h0efd2, 1'b0, 8'h55, -1, 0, 25'h0efd2, 11'h000, 8'hef, 0,
           1'b1);
    access("csr0_clear", 25'h0efd0, 1'b0, 8'h00, -1, 0, 25'h0efd0, 11'h000, 8'h84, 0, 1'b1);
    access("csr0_cleared", 25'h0efd0, 1'b1, 8'h00, -1, 0, 25'h0efd0, 11'h000, 8'h00, 0,
           1'b0);
    access("overlap_1_3", 25'h28000, 1'b1, 8'h00, -1, 0, 25'h28000, 11'h002, 8'hA1, 0, 1'b0);
    access("slot3_only", 25'h30000, 1'b1, 8'h00, -1, 0, 25'h30000, 11'h008, 8'hA3, 0, 1'b0);
    access("abort_again", 25'h0efe6, 1'b1, 8'h00, 4, 1000, 25'h0efe6, 11'h000, 8'hFF,
           int'(TO) + 1, 1'b0);

    // Start a slot-0 stall, then reset in the middle of it.
    bus.i_addr = 25'h01234;
    @(negedge clk);
    chk("pre_reset_stall_rdy", 32'(bus.o_rdy), 32'd0);
    chk("pre_reset_irq", 32'(bus.o_irq), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("in_reset_rdy", 32'(bus.o_rdy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    access("post_reset_zero", 25'h0eff9, 1'b1, 8'h00, -1, 0, 25'h0eff9, 11'h004, 8'hA2, 0,
           1'b0);
    access("post_reset_csr0", 25'h0efd0, 1'b1, 8'h00, -1, 0, 25'h0efd0, 11'h000, 8'h00, 0,
           1'b0);
    access("post_reset_csr1", 25'h0efd1, 1'b1, 8'h00, -1, 0, 25'h0efd1, 11'h000, 8'h00, 0,
           1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
